// File: rtl/cheri_dmem_pkg.sv
// ----------------------------------------------------------------------------
// cheri_dmem_pkg
// Shared types and constants for the CHERIoT data-memory responder.
//   TagBit   : index of the capability tag bit on the 33-bit data bus
//   BusWidth : full bus data width (32 data bits + tag)
//   resp_t   : one response-pipeline slot {valid, err, rdata}
// ----------------------------------------------------------------------------
package cheri_dmem_pkg;

   localparam int TagBit   = 32;
   localparam int BusWidth = TagBit + 1;

   typedef struct packed {
      logic                valid;
      logic                err;
      logic [BusWidth-1:0] rdata;
   } resp_t;

endpackage : cheri_dmem_pkg

// File: rtl/cheri_dmem_resp_pipe.sv
// ----------------------------------------------------------------------------
// cheri_dmem_resp_pipe
// Fixed-latency response shift register. A slot entering at resp_i appears
// at resp_o exactly Depth cycles later. Never back-pressures.
// Ports:
//   clk_i   in   clock
//   rst_i   in   synchronous active-high reset, empties every stage
//   resp_i  in   response produced in the accept cycle
//   resp_o  out  response presented on the bus
// ----------------------------------------------------------------------------
module cheri_dmem_resp_pipe
   import cheri_dmem_pkg::*;
#(
   parameter int Depth = 1
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  resp_t resp_i,
   output resp_t resp_o
);

   resp_t stage_q [Depth];
   resp_t stage_d [Depth];

   always_comb begin
      stage_d[0] = resp_i;
      for (int i = 1; i < Depth; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // stage samples the value its neighbour held before this edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < Depth; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < Depth; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign resp_o = stage_q[Depth-1];

endmodule : cheri_dmem_resp_pipe

// File: rtl/cheri_dmem_responder.sv
// ----------------------------------------------------------------------------
// cheri_dmem_responder
// Memory-side responder for the CHERIoT data bus (req/gnt/rvalid). Backs a
// tagged, word-addressed SRAM window, applies the tag-clearing rules, and
// offers grant stalls, fixed response latency and one-shot error injection.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   data_req_i        request valid
//   data_gnt_o        request accepted this cycle (combinational)
//   data_we_i         write
//   data_be_i         byte enables
//   data_addr_i       byte address, bits 1:0 ignored
//   data_is_cap_i     capability access, tag meaningful
//   data_wdata_i      write data, top bit is the tag
//   data_rvalid_o     response valid
//   data_rdata_o      read data, top bit is the tag
//   data_err_o        response error, qualified by data_rvalid_o
//   stall_i           suppress grant this cycle
//   err_inject_i      arm an error for the next accepted request
//   acc_count_o       accepted-request counter (wraps)
// ----------------------------------------------------------------------------
module cheri_dmem_responder
   import cheri_dmem_pkg::*;
#(
   parameter logic [31:0] AddrBase    = 32'h2000_0000,
   parameter int          MemWords    = 4096,
   parameter int          DataWidth   = 33,
   parameter int          RespLatency = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 data_req_i,
   output logic                 data_gnt_o,
   input  logic                 data_we_i,
   input  logic [3:0]           data_be_i,
   input  logic [31:0]          data_addr_i,
   input  logic                 data_is_cap_i,
   input  logic [DataWidth-1:0] data_wdata_i,
   output logic                 data_rvalid_o,
   output logic [DataWidth-1:0] data_rdata_o,
   output logic                 data_err_o,
   input  logic                 stall_i,
   input  logic                 err_inject_i,
   output logic [31:0]          acc_count_o
);

   localparam int          IdxW     = $clog2(MemWords);
   localparam logic [31:0] WinBytes = 32'(MemWords * 4);

   logic                 accept;
   logic [31:0]          off;
   logic                 in_range;
   logic [IdxW-1:0]      idx;
   logic                 req_err;
   logic                 wr_en;
   logic [DataWidth-1:0] rd_word;
   logic [DataWidth-1:0] wr_word;

   logic                 arm_q, arm_d;
   logic [31:0]          acc_count_q, acc_count_d;

   logic [DataWidth-1:0] mem_q [MemWords];

   resp_t                resp_in;
   resp_t                resp_out;

   // ---------------------------------------------------------------------
   // Handshake and decode
   // ---------------------------------------------------------------------
   assign data_gnt_o = data_req_i & ~stall_i & ~rst_i;
   assign accept     = data_req_i & data_gnt_o;

   // Unsigned subtraction: addresses below the base wrap to huge offsets and
   // therefore fail the range compare without a second comparator.
   assign off      = data_addr_i - AddrBase;
   assign in_range = off < WinBytes;
   assign idx      = off[IdxW+1:2];
   assign req_err  = ~in_range | arm_q;

   // Combinational read in the accept cycle. Requests are serialized, so a
   // write committed at the previous edge is already visible here and a
   // following same-word read needs no bypass path.
   assign rd_word = mem_q[idx];

   // ---------------------------------------------------------------------
   // Write merge: byte-lane update, tag survives only a full-word cap write
   // ---------------------------------------------------------------------
   // NOTE: every variable in an always_comb gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_word = rd_word;
      for (int b = 0; b < 4; b++) begin
         if (data_be_i[b]) begin
            wr_word[8*b +: 8] = data_wdata_i[8*b +: 8];
         end
      end
      wr_word[TagBit] = data_is_cap_i & (data_be_i == 4'hF) & data_wdata_i[TagBit];
   end

   assign wr_en = accept & data_we_i & ~req_err;

   // NOTE: the storage array has no reset; its contents are undefined after
   // power-up and a reset would prevent mapping it onto block RAM.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[idx] <= wr_word;
      end
   end

   // ---------------------------------------------------------------------
   // Response slot built in the accept cycle
   // ---------------------------------------------------------------------
   always_comb begin
      resp_in       = '0;
      resp_in.valid = accept;
      resp_in.err   = accept & req_err;
      if (accept & ~data_we_i & ~req_err) begin
         resp_in.rdata[TagBit-1:0] = rd_word[TagBit-1:0];
         resp_in.rdata[TagBit]     = rd_word[TagBit] & data_is_cap_i;
      end
   end

   cheri_dmem_resp_pipe #(
      .Depth (RespLatency)
   ) u_resp_pipe (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .resp_i (resp_in),
      .resp_o (resp_out)
   );

   assign data_rvalid_o = resp_out.valid;
   assign data_err_o    = resp_out.err;
   assign data_rdata_o  = resp_out.rdata;

   // ---------------------------------------------------------------------
   // Error-inject arm and accept counter
   // ---------------------------------------------------------------------
   // An inject pulse coinciding with an accept re-arms for the following
   // accept; the accept itself consumes only the previously armed state.
   always_comb begin
      arm_d = arm_q;
      if (accept) begin
         arm_d = err_inject_i;
      end else if (err_inject_i) begin
         arm_d = 1'b1;
      end
      acc_count_d = acc_count_q + 32'(accept);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         arm_q       <= 1'b0;
         acc_count_q <= '0;
      end else begin
         arm_q       <= arm_d;
         acc_count_q <= acc_count_d;
      end
   end

   assign acc_count_o = acc_count_q;

endmodule : cheri_dmem_responder

// File: tb/tb_cheri_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_cheri_dmem_responder
// Directed scenarios plus randomized traffic against a behavioural model of
// the responder. The driver pushes each expected response (with its due
// cycle) into a queue; an independent monitor compares on every cycle.
// ----------------------------------------------------------------------------
module tb_cheri_dmem_responder;

   localparam logic [31:0] Base  = 32'h2000_0000;
   localparam int          Words = 4096;
   localparam int          Lat   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        gnt;
   logic        we = 1'b0;
   logic [3:0]  be = 4'h0;
   logic [31:0] addr = Base;
   logic        is_cap = 1'b0;
   logic [32:0] wdata = '0;
   logic        rvalid;
   logic [32:0] rdata;
   logic        err;
   logic        stall = 1'b0;
   logic        inject = 1'b0;
   logic [31:0] acc_count;

   cheri_dmem_responder #(
      .AddrBase    (Base),
      .MemWords    (Words),
      .DataWidth   (33),
      .RespLatency (Lat)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .data_req_i    (req),
      .data_gnt_o    (gnt),
      .data_we_i     (we),
      .data_be_i     (be),
      .data_addr_i   (addr),
      .data_is_cap_i (is_cap),
      .data_wdata_i  (wdata),
      .data_rvalid_o (rvalid),
      .data_rdata_o  (rdata),
      .data_err_o    (err),
      .stall_i       (stall),
      .err_inject_i  (inject),
      .acc_count_o   (acc_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          due;
      logic        err;
      logic [32:0] rdata;
   } exp_t;

   exp_t        exp_q [$];
   logic [32:0] ref_mem [int];
   logic        ref_arm   = 1'b0;
   logic [31:0] ref_count = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
      end
   endtask

   // Behavioural view of one accepted request.
   task automatic model_accept(input logic wr, input logic [3:0] ben, input logic [31:0] a,
                               input logic cap, input logic [32:0] wd);
      logic [31:0] offs;
      int          widx;
      logic        e;
      logic [31:0] mask;
      logic [32:0] old;
      logic [32:0] rd;
      offs = a - Base;
      widx = int'(offs >> 2);
      e    = (offs >= 32'(Words * 4)) || ref_arm;
      rd   = '0;
      if (!e) begin
         old = ref_mem.exists(widx) ? ref_mem[widx] : 33'h0;
         if (wr) begin
            mask = {{8{ben[3]}}, {8{ben[2]}}, {8{ben[1]}}, {8{ben[0]}}};
            ref_mem[widx] = {cap && ben == 4'hF && wd[32],
                             (old[31:0] & ~mask) | (wd[31:0] & mask)};
         end else begin
            rd = {old[32] & cap, old[31:0]};
         end
      end
      ref_count++;
      exp_q.push_back('{due: cyc + Lat, err: e, rdata: rd});
   endtask

   // One bus cycle of stimulus; checks the counter and the grant on the way.
   task automatic issue(input logic r, input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic cap, input logic [32:0] wd, input logic st, input logic inj);
      @(posedge clk);
      #1;
      check("acc_count", 64'(acc_count), 64'(ref_count));
      req = r; we = w; be = b; addr = a; is_cap = cap; wdata = wd; stall = st; inject = inj;
      #1;
      check("gnt", 64'(gnt), 64'(r & ~st));
      if (r && !st) begin
         model_accept(w, b, a, cap, wd);
         ref_arm = inj;
      end else if (inj) begin
         ref_arm = 1'b1;
      end
   endtask

   task automatic idle();
      issue(1'b0, 1'b0, 4'h0, Base, 1'b0, 33'h0, 1'b0, 1'b0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic cap, input logic [32:0] wd);
      issue(1'b1, 1'b1, b, a, cap, wd, 1'b0, 1'b0);
   endtask

   task automatic rd(input logic [31:0] a, input logic cap);
      issue(1'b1, 1'b0, 4'hF, a, cap, 33'h0, 1'b0, 1'b0);
   endtask

   task automatic do_reset(input int n);
      exp_t keep [$];
      @(posedge clk);
      #1;
      rst = 1'b1; req = 1'b1; we = 1'b0; stall = 1'b0; inject = 1'b0; addr = Base;
      // Responses already on the bus this cycle survive; later ones are lost.
      foreach (exp_q[i]) if (exp_q[i].due <= cyc) keep.push_back(exp_q[i]);
      exp_q     = keep;
      ref_arm   = 1'b0;
      ref_count = '0;
      #1;
      check("gnt_in_reset", 64'(gnt), 64'h0);
      repeat (n) @(posedge clk);
      #1;
      check("rvalid_in_reset", 64'(rvalid), 64'h0);
      check("err_in_reset", 64'(err), 64'h0);
      check("rdata_in_reset", 64'(rdata), 64'h0);
      check("acc_count_in_reset", 64'(acc_count), 64'h0);
      rst = 1'b0; req = 1'b0;
   endtask

   // Monitor: every cycle, rvalid must match whether a response is due now.
   always @(negedge clk) begin
      logic due_now;
      due_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check("rvalid", 64'(rvalid), 64'(due_now));
      if (due_now) begin
         if (rvalid) begin
            check("err", 64'(err), 64'(exp_q[0].err));
            check("rdata", 64'(rdata), 64'(exp_q[0].rdata));
         end
         void'(exp_q.pop_front());
      end
   end

   initial begin
      #2_000_000;
      bad++;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      do_reset(3);

      // Known contents for a pool of words 0..15.
      for (int i = 0; i < 16; i++) begin
         wr(Base + 32'(4 * i), 4'hF, 1'b1, {1'($urandom_range(0, 1)), 32'($urandom)});
      end

      // Full cap write then cap read round-trips the tag.
      wr(Base + 32'h10, 4'hF, 1'b1, 33'h1_DEAD_BEEF);
      rd(Base + 32'h10, 1'b1);
      // Partial write clears the tag; read issued the very next cycle.
      wr(Base + 32'h10, 4'h1, 1'b0, 33'h0_0000_00AA);
      rd(Base + 32'h10, 1'b1);
      // Cap write with tag followed by a non-cap read masks the tag.
      wr(Base + 32'h14, 4'hF, 1'b1, 33'h1_0BAD_F00D);
      rd(Base + 32'h14, 1'b0);
      rd(Base + 32'h14, 1'b1);

      // Out-of-range on both sides, then a normal write/read.
      rd(Base - 32'h4, 1'b1);
      rd(Base + 32'(Words * 4), 1'b1);
      wr(Base + 32'h3FFC, 4'hF, 1'b1, 33'h1_CAFE_0001);
      rd(Base + 32'h3FFC, 1'b1);
      wr(Base - 32'h4, 4'hF, 1'b0, 33'h0_1111_1111);
      rd(Base + 32'h3FFC, 1'b1);

      // Injected error blocks a write; the next request is clean.
      issue(1'b0, 1'b0, 4'h0, Base, 1'b0, 33'h0, 1'b0, 1'b1);
      wr(Base + 32'hC, 4'hF, 1'b0, 33'h0_1234_5678);
      rd(Base + 32'hC, 1'b1);
      // Inject coinciding with an accept hits the following accept only.
      issue(1'b1, 1'b0, 4'hF, Base + 32'h8, 1'b1, 33'h0, 1'b0, 1'b1);
      rd(Base + 32'h8, 1'b1);
      rd(Base + 32'h8, 1'b1);

      // Stall with request held, then back-to-back reads.
      do_reset(2);
      for (int i = 0; i < 3; i++) issue(1'b1, 1'b0, 4'hF, Base, 1'b1, 33'h0, 1'b1, 1'b0);
      rd(Base, 1'b1);
      for (int i = 0; i < 8; i++) rd(Base + 32'(4 * i), 1'b1);
      idle();
      check("acc_count_after_burst", 64'(acc_count), 64'd9);

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         logic        w;
         logic [3:0]  b;
         int          pick;
         pick = int'($urandom_range(0, 19));
         if (pick == 0)      a = Base - 32'(4 * $urandom_range(1, 8));
         else if (pick == 1) a = Base + 32'(Words * 4) + 32'(4 * $urandom_range(0, 8));
         else                a = Base + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
         w = 1'($urandom_range(0, 1));
         b = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
         issue(1'($urandom_range(0, 9) != 0), w, b, a, 1'($urandom_range(0, 1)),
               {1'($urandom_range(0, 1)), 32'($urandom)},
               1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 15) == 0));
      end

      // Reset with responses still in flight.
      idle();
      idle();
      rd(Base, 1'b1);
      rd(Base + 32'h4, 1'b1);
      rd(Base + 32'h8, 1'b1);
      do_reset(2);
      idle();
      check("acc_count_after_reset", 64'(acc_count), 64'h0);

      repeat (Lat + 3) @(posedge clk);
      #1;
      check("queue_drained", 64'(exp_q.size()), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_cheri_dmem_responder
